// File: rtl/inv_matrix_seq_ctrl.sv
// Sequencer for the NxN matrix-inverse datapath: loads operands from the coefficient ROM,
// kicks the datapath under a watchdog, then streams the result words out row-major.
module inv_matrix_seq_ctrl #(
    parameter int DW      = 32,
    parameter int N       = 5,
    parameter int AW      = 5,
    parameter int ROM_LAT = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          ld_en,
    output logic [AW-1:0] ld_idx,
    output logic [DW-1:0] ld_data,
    output logic          dp_start,
    input  logic          dp_done,
    input  logic          dp_singular,
    output logic [AW-1:0] res_idx,
    input  logic [DW-1:0] res_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int NE  = N * N;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(NE - 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, STREAM, FAIL} state_t;

    state_t state;
    state_t state_next;

    logic               issuing;
    logic               xfer;
    logic [WDW-1:0]     wd_cnt;
    logic [ROM_LAT-1:0] ld_vld_pipe;
    logic [AW-1:0]      ld_idx_pipe [ROM_LAT];

    assign xfer     = (state == STREAM) && out_ready;
    assign ld_data  = rom_data;
    assign out_data = res_data;
    assign ld_en    = ld_vld_pipe[ROM_LAT-1];
    assign ld_idx   = ld_idx_pipe[ROM_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // LOAD ends one cycle after the delayed write of the final element.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (ld_en && (ld_idx == LAST_IDX)) state_next = KICK;
            KICK:    state_next = WAIT;
            WAIT: begin
                if (dp_done) begin
                    state_next = dp_singular ? FAIL : STREAM;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_next = FAIL;
                end
            end
            STREAM:  if (xfer && (res_idx == LAST_IDX)) state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        dp_start  = (state == KICK);
        out_valid = (state == STREAM);
        out_last  = (state == STREAM) && (res_idx == LAST_IDX);
        done      = (state == FAIL) || (xfer && (res_idx == LAST_IDX));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rom_addr <= '0;
            issuing  <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            wd_cnt   <= '0;
            res_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rom_addr <= '0;
                        issuing  <= 1'b1;
                        error    <= 1'b0;
                        err_code <= 2'b00;
                    end
                end
                LOAD: begin
                    if (issuing) begin
                        if (rom_addr == LAST_IDX) begin
                            issuing <= 1'b0;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                end
                KICK: wd_cnt <= '0;
                WAIT: begin
                    if (wd_cnt != WD_LIMIT) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    // A completion on the timeout cycle still counts as a completion.
                    if (dp_done) begin
                        if (dp_singular) begin
                            err_code <= 2'b01;
                        end else begin
                            res_idx <= '0;
                        end
                    end else if (wd_cnt == WD_LIMIT) begin
                        err_code <= 2'b10;
                    end
                end
                STREAM: begin
                    if (out_ready && (res_idx != LAST_IDX)) begin
                        res_idx <= res_idx + 1'b1;
                    end
                end
                FAIL: error <= 1'b1;
                default: ;
            endcase
        end
    end

    // Write strobe and index trail each issued address by the ROM latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_vld_pipe <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                ld_idx_pipe[i] <= '0;
            end
        end else begin
            ld_vld_pipe[0] <= (state == LOAD) && issuing;
            ld_idx_pipe[0] <= rom_addr;
            for (int i = 1; i < ROM_LAT; i++) begin
                ld_vld_pipe[i] <= ld_vld_pipe[i-1];
                ld_idx_pipe[i] <= ld_idx_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_inv_matrix_seq_ctrl.sv
// Bench for inv_matrix_seq_ctrl: two instances (ROM latency 1 and 3) driven from an operation
// table; every cycle is compared against a timeline derived from the sequencing rules.
module tb_inv_matrix_seq_ctrl;

    localparam int DW = 32;
    localparam int N  = 5;
    localparam int NE = N * N;
    localparam int AW = 5;

    typedef struct {
        int         inst;
        bit         sing;
        int         dp_delay;
        int         ready_mode;
        bit         noise;
        bit         identity;
        bit         exp_err;
        logic [1:0] exp_code;
        int         exp_xfers;
    } op_vec_t;

    logic clk = 1'b0;
    logic reset;

    logic          start_s     [2];
    logic          dp_done_s   [2];
    logic          dp_sing_s   [2];
    logic          out_ready_s [2];
    logic          busy_s      [2];
    logic          done_s      [2];
    logic          error_s     [2];
    logic          ld_en_s     [2];
    logic          dp_start_s  [2];
    logic          out_valid_s [2];
    logic          out_last_s  [2];
    logic [1:0]    err_code_s  [2];
    logic [AW-1:0] rom_addr_s  [2];
    logic [AW-1:0] ld_idx_s    [2];
    logic [AW-1:0] res_idx_s   [2];
    logic [DW-1:0] rom_data_s  [2];
    logic [DW-1:0] ld_data_s   [2];
    logic [DW-1:0] res_data_s  [2];
    logic [DW-1:0] out_data_s  [2];

    logic [DW-1:0] rom_mem [NE];
    logic [DW-1:0] res_salt;

    int checks;
    int passes;
    op_vec_t vecs [12];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int timeout_of(input int g);
        return (g == 0) ? 16 : 32;
    endfunction

    function automatic logic [DW-1:0] res_word(input int idx);
        return res_salt ^ (32'(idx) * 32'h0101_0101 + 32'd7);
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Synchronous ROM and combinational result memory seen by each instance.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] pipe [L];
        always @(posedge clk) begin
            pipe[0] <= rom_mem[rom_addr_s[g]];
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign rom_data_s[g] = pipe[L-1];
        assign res_data_s[g] = res_salt ^ (32'(res_idx_s[g]) * 32'h0101_0101 + 32'd7);

        inv_matrix_seq_ctrl #(
            .DW(DW), .N(N), .AW(AW), .ROM_LAT(L), .TIMEOUT((g == 0) ? 16 : 32)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .error(error_s[g]), .err_code(err_code_s[g]),
            .rom_addr(rom_addr_s[g]), .rom_data(rom_data_s[g]),
            .ld_en(ld_en_s[g]), .ld_idx(ld_idx_s[g]), .ld_data(ld_data_s[g]),
            .dp_start(dp_start_s[g]), .dp_done(dp_done_s[g]), .dp_singular(dp_sing_s[g]),
            .res_idx(res_idx_s[g]), .res_data(res_data_s[g]),
            .out_valid(out_valid_s[g]), .out_ready(out_ready_s[g]),
            .out_data(out_data_s[g]), .out_last(out_last_s[g])
        );
    end

    task automatic apply_stimulus(input int g, input bit st, input bit dd, input bit ds, input bit rdy);
        start_s[g]     = st;
        dp_done_s[g]   = dd;
        dp_sing_s[g]   = ds;
        out_ready_s[g] = rdy;
    endtask

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_reset_zero(input int g, input string tag);
        check_output({tag, "_busy"},      64'(busy_s[g]),      64'd0);
        check_output({tag, "_done"},      64'(done_s[g]),      64'd0);
        check_output({tag, "_error"},     64'(error_s[g]),     64'd0);
        check_output({tag, "_err_code"},  64'(err_code_s[g]),  64'd0);
        check_output({tag, "_rom_addr"},  64'(rom_addr_s[g]),  64'd0);
        check_output({tag, "_ld_en"},     64'(ld_en_s[g]),     64'd0);
        check_output({tag, "_ld_idx"},    64'(ld_idx_s[g]),    64'd0);
        check_output({tag, "_dp_start"},  64'(dp_start_s[g]),  64'd0);
        check_output({tag, "_res_idx"},   64'(res_idx_s[g]),   64'd0);
        check_output({tag, "_out_valid"}, 64'(out_valid_s[g]), 64'd0);
        check_output({tag, "_out_last"},  64'(out_last_s[g]),  64'd0);
    endtask

    // Runs one operation from an IDLE cycle; returns at the sample point of the first IDLE cycle after it.
    task automatic run_op(input op_vec_t v, output bit got_err, output logic [1:0] got_code, output int xfers);
        int g, lat, to, kick, e, cyc;
        bit rdy, dpd, done_seen;
        logic [1:0] want_code;
        g = v.inst;
        lat = lat_of(g);
        to = timeout_of(g);
        kick = NE + lat;
        xfers = 0;
        done_seen = 1'b0;
        for (int i = 0; i < NE; i++) begin
            rom_mem[i] = v.identity ? ((i % (N + 1) == 0) ? 32'd1 : 32'd0) : 32'($urandom);
        end
        res_salt = 32'($urandom);
        apply_stimulus(g, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k <= kick; k++) begin
            if (v.noise && k < kick) apply_stimulus(g, rb(), rb(), rb(), rb());
            else apply_stimulus(g, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            if (k == 0) begin
                check_output("load_error_cleared", 64'(error_s[g]), 64'd0);
                check_output("load_code_cleared", 64'(err_code_s[g]), 64'd0);
            end
            check_output("load_busy", 64'(busy_s[g]), 64'd1);
            check_output("load_rom_addr", 64'(rom_addr_s[g]), 64'((k < NE) ? k : NE - 1));
            check_output("load_ld_en", 64'(ld_en_s[g]), 64'(k >= lat && k < kick));
            if (k >= lat && k < kick) begin
                check_output("load_ld_idx", 64'(ld_idx_s[g]), 64'(k - lat));
                check_output("load_ld_data", 64'(ld_data_s[g]), 64'(rom_mem[k - lat]));
            end
            check_output("load_dp_start", 64'(dp_start_s[g]), 64'(k == kick));
            check_output("load_out_valid", 64'(out_valid_s[g]), 64'd0);
            check_output("load_done", 64'(done_s[g]), 64'd0);
            @(posedge clk); #1;
        end
        for (int w = 0; w < to; w++) begin
            dpd = (v.dp_delay > 0) && (w == v.dp_delay - 1);
            apply_stimulus(g, v.noise ? rb() : 1'b0, dpd, dpd ? v.sing : (v.noise ? rb() : 1'b0), 1'b0);
            #1;
            check_output("wait_busy", 64'(busy_s[g]), 64'd1);
            check_output("wait_dp_start", 64'(dp_start_s[g]), 64'd0);
            check_output("wait_out_valid", 64'(out_valid_s[g]), 64'd0);
            check_output("wait_done", 64'(done_s[g]), 64'd0);
            @(posedge clk); #1;
            if (dpd) begin
                done_seen = 1'b1;
                break;
            end
        end
        if (!done_seen || v.sing) begin
            want_code = done_seen ? 2'b01 : 2'b10;
            apply_stimulus(g, v.noise ? rb() : 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check_output("fail_done", 64'(done_s[g]), 64'd1);
            check_output("fail_busy", 64'(busy_s[g]), 64'd1);
            check_output("fail_out_valid", 64'(out_valid_s[g]), 64'd0);
            @(posedge clk); #1;
        end else begin
            want_code = 2'b00;
            e = 0;
            cyc = 0;
            while (e < NE && cyc < 400) begin
                case (v.ready_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = rb();
                endcase
                apply_stimulus(g, v.noise ? rb() : 1'b0, v.noise ? rb() : 1'b0, v.noise ? rb() : 1'b0, rdy);
                #1;
                check_output("stream_out_valid", 64'(out_valid_s[g]), 64'd1);
                check_output("stream_busy", 64'(busy_s[g]), 64'd1);
                check_output("stream_res_idx", 64'(res_idx_s[g]), 64'(e));
                check_output("stream_out_data", 64'(out_data_s[g]), 64'(res_word(e)));
                check_output("stream_out_last", 64'(out_last_s[g]), 64'(e == NE - 1));
                check_output("stream_done", 64'(done_s[g]), 64'(rdy && e == NE - 1));
                if (out_valid_s[g] && rdy) xfers++;
                if (rdy) e++;
                cyc++;
                @(posedge clk); #1;
            end
            if (e < NE) check_output("stream_bound", 64'(e), 64'(NE));
        end
        apply_stimulus(g, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_output("idle_busy", 64'(busy_s[g]), 64'd0);
        check_output("idle_done", 64'(done_s[g]), 64'd0);
        check_output("idle_out_valid", 64'(out_valid_s[g]), 64'd0);
        check_output("idle_error", 64'(error_s[g]), 64'(want_code != 2'b00));
        check_output("idle_err_code", 64'(err_code_s[g]), 64'(want_code));
        got_err = error_s[g];
        got_code = err_code_s[g];
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got %0d/%0d", passes, checks);
        $fatal(1, "[TB] aborted");
    end

    initial begin
        bit         ge;
        logic [1:0] gc;
        int         gx;
        checks = 0;
        passes = 0;
        res_salt = '0;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) apply_stimulus(g, 1'b0, 1'b0, 1'b0, 1'b0);

        //          inst sing delay mode noise ident  err  code   xfers
        vecs[0]  = '{0, 1'b0, 10, 0, 1'b0, 1'b1, 1'b0, 2'b00, 25};
        vecs[1]  = '{1, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 2'b00, 25};
        vecs[2]  = '{0, 1'b0,  5, 1, 1'b0, 1'b0, 1'b0, 2'b00, 25};
        vecs[3]  = '{0, 1'b1,  7, 0, 1'b0, 1'b0, 1'b1, 2'b01,  0};
        vecs[4]  = '{0, 1'b0,  3, 0, 1'b0, 1'b0, 1'b0, 2'b00, 25};
        vecs[5]  = '{0, 1'b0, -1, 0, 1'b1, 1'b0, 1'b1, 2'b10,  0};
        vecs[6]  = '{1, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, 2'b10,  0};
        vecs[7]  = '{1, 1'b0, 15, 2, 1'b1, 1'b0, 1'b0, 2'b00, 25};
        vecs[8]  = '{1, 1'b1,  1, 0, 1'b0, 1'b0, 1'b1, 2'b01,  0};
        vecs[9]  = '{0, 1'b0, 16, 0, 1'b0, 1'b0, 1'b0, 2'b00, 25};
        vecs[10] = '{1, 1'b1, 32, 1, 1'b0, 1'b0, 1'b1, 2'b01,  0};
        vecs[11] = '{0, 1'b0,  2, 2, 1'b1, 1'b0, 1'b0, 2'b00, 25};

        repeat (3) @(posedge clk);
        #2;
        for (int g = 0; g < 2; g++) check_reset_zero(g, "por");
        reset = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i], ge, gc, gx);
            check_output($sformatf("vec%0d_error", i), 64'(ge), 64'(vecs[i].exp_err));
            check_output($sformatf("vec%0d_err_code", i), 64'(gc), 64'(vecs[i].exp_code));
            check_output($sformatf("vec%0d_transfers", i), 64'(gx), 64'(vecs[i].exp_xfers));
        end

        // Reset asserted on the 12th LOAD cycle, with start also high, must abort cleanly.
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int k = 0; k < 11; k++) begin
            apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check_output("rst_pre_rom_addr", 64'(rom_addr_s[0]), 64'(k));
            @(posedge clk); #1;
        end
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_reset_zero(0, "rst_mid");
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            check_output("rst_after_busy", 64'(busy_s[0]), 64'd0);
            check_output("rst_after_dp_start", 64'(dp_start_s[0]), 64'd0);
            check_output("rst_after_ld_en", 64'(ld_en_s[0]), 64'd0);
            check_output("rst_after_out_valid", 64'(out_valid_s[0]), 64'd0);
        end
        run_op(vecs[0], ge, gc, gx);
        check_output("rst_rerun_error", 64'(ge), 64'd0);
        check_output("rst_rerun_transfers", 64'(gx), 64'(NE));

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inv_matrix_seq_ctrl.md
Name: inv_matrix_seq_ctrl

Overview:
Sequencer for the 5x5 matrix-inverse datapath. On a start request it:
- streams N*N operand words from the synchronous coefficient ROM into the datapath load port;
- kicks the datapath and waits for completion, with a watchdog;
- streams the N*N result words out over a valid/ready interface in row-major order.

It sits between the system controller / host and the inverse datapath. It owns all ROM addressing and datapath handshakes.

Parameters:
DW, 32, data word width (ROM, datapath, output stream)
N, 5, matrix dimension; element count NE = N*N = 25
AW, 5, index width; must satisfy 2^AW >= NE
ROM_LAT, 1, ROM read latency in cycles (address to data); legal range 1..3
TIMEOUT, 1024, maximum WAIT cycles before a datapath-hang error

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
start  in  1  request a new inversion; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when an operation ends (success or failure)
error  out  1  sticky failure flag; cleared on the next accepted start
err_code  out  2  00 none, 01 singular, 10 timeout; valid while error=1
rom_addr  out  AW  ROM read address (registered)
rom_data  in  DW  ROM read data, valid ROM_LAT cycles after rom_addr
ld_en  out  1  datapath operand write strobe
ld_idx  out  AW  operand index 0..NE-1, row-major
ld_data  out  DW  operand word (= rom_data)
dp_start  out  1  one-cycle pulse: begin elimination
dp_done  in  1  datapath completion pulse
dp_singular  in  1  qualified by dp_done: zero pivot detected
res_idx  out  AW  result read index (registered)
res_data  in  DW  datapath result word at res_idx (combinational, stable until next dp_start)
out_valid  out  1  result word available
out_ready  in  1  consumer accepts
out_data  out  DW  = res_data
out_last  out  1  high with out_valid when res_idx = NE-1

Behaviour:
Reset (reset=0 at a clock edge):
- state goes to IDLE.
- All outputs go to 0: busy, done, error, err_code, rom_addr, ld_en, ld_idx, dp_start, res_idx, out_valid, out_last.
- Reset overrides any in-flight operation. No dp_start is issued and no partial stream completes afterwards.

States: IDLE, LOAD, KICK, WAIT, STREAM, FAIL.

IDLE:
- start=1 -> LOAD; rom_addr<=0, error<=0, err_code<=00, address counter<=0.

LOAD:
- rom_addr increments by 1 each cycle through NE-1, then holds.
- ld_en/ld_idx form a delay line of the address issue: element i is written (ld_en=1, ld_idx=i, ld_data=rom_data) exactly ROM_LAT cycles after rom_addr=i.
- Writes occupy NE consecutive cycles with no gaps.
- -> KICK on the cycle after the write of index NE-1.
- LOAD lasts NE+ROM_LAT cycles.

KICK:
- dp_start=1 for exactly one cycle; watchdog counter cleared; -> WAIT.

WAIT:
- Watchdog increments each cycle.
- dp_done=1 and dp_singular=0 -> STREAM, res_idx<=0.
- dp_done=1 and dp_singular=1 -> FAIL, err_code<=01.
- Watchdog reaches TIMEOUT-1 with no dp_done -> FAIL, err_code<=10.
- If dp_done coincides with the timeout cycle, dp_done wins.
- dp_done seen in any other state is ignored.

STREAM:
- out_valid=1.
- Transfer occurs when out_valid & out_ready; res_idx increments per transfer.
- While out_ready=0, res_idx, out_data and out_last hold.
- Transfer with out_last=1 -> IDLE next cycle, done=1 for that cycle, out_valid drops the same cycle.
- No bubbles: NE transfers take exactly NE cycles when out_ready is tied high.

FAIL:
- error<=1, done=1 for one cycle; -> IDLE.
- No output stream is produced.

Start handling:
- start while busy=1 is ignored: not queued, no effect.
- start sampled in IDLE in the same cycle done pulses is not possible, because done is asserted while leaving STREAM/FAIL.
- start on the first IDLE cycle after done is accepted, giving back-to-back operations.

Arithmetic and widths:
- Counters are AW bits and never wrap. The counter compare uses NE-1.
- The watchdog is clog2(TIMEOUT) bits.

Test Plan:
1. ROM holds the identity matrix, ROM_LAT=1, datapath model asserts dp_done 10 cycles after dp_start, out_ready=1. Start -> ld_en high for 25 consecutive cycles with ld_idx 0..24; dp_start a single pulse; 25 transfers with out_last on the 25th; done pulse; error=0; busy low 1 cycle later.
2. ROM_LAT=3 -> first ld_en exactly 3 cycles after rom_addr=0; ld_idx/ld_data alignment holds for all 25 words; LOAD lasts 28 cycles.
3. Backpressure: out_ready toggles 1,0,0,1 repeating -> out_data/res_idx stable during stalls; exactly 25 transfers in order; done only after the 25th.
4. Datapath returns dp_done with dp_singular=1 -> no out_valid; done pulse; error=1, err_code=01. Next start clears error to 0.
5. Datapath never responds, TIMEOUT=16 -> FAIL after 16 WAIT cycles; err_code=10. Also: start pulses during LOAD/WAIT/STREAM have no effect.
6. reset=0 asserted on the 12th LOAD cycle -> next cycle all outputs 0 and state IDLE; a subsequent start runs the full sequence from rom_addr=0.
